universal_shift_register: RTL and testbench

- Parametrised successor to the team's fixed 4-bit register: WIDTH-bit register with parallel load, shift, rotate and synchronous clear.
- Adds a built-in serial-transfer sequencer. One START pulse loads a word, shifts it out LSB-first over WIDTH cycles, and captures a word from SER_IN at the same time (full-duplex).
- Used as a datapath register and as the serial engine for the team's point-to-point serial links.

---
 rtl/universal_shift_register.sv | 86 ++++++++
 tb/tb_universal_shift_register.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: parallel load, shift, rotate, synchronous clear,
// plus a START-triggered full-duplex serial transfer sequencer (LSB first).
module universal_shift_register #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             ser_in,
   input  logic             start,
   output logic [WIDTH-1:0] q,
   output logic             ser_out,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_nxt;
   logic             done_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         q     <= '0;
         count <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         q     <= q_nxt;
         count <= count_nxt;
         done  <= done_nxt;
      end
   end

   // Clear beats everything; START is only seen in IDLE, and a running transfer ignores mode inputs.
   always_comb begin
      state_nxt = state;
      q_nxt     = q;
      count_nxt = count;
      done_nxt  = 1'b0;
      if (clr) begin
         state_nxt = IDLE;
         q_nxt     = '0;
         count_nxt = '0;
      end else if (state == IDLE) begin
         if (start) begin
            q_nxt     = d;
            count_nxt = CW'(WIDTH);
            state_nxt = SHIFT;
         end else if (en) begin
            case (mode)
               3'b001:  q_nxt = d;
               3'b010:  q_nxt = {q[WIDTH-2:0], ser_in};
               3'b011:  q_nxt = {ser_in, q[WIDTH-1:1]};
               3'b100:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
               3'b101:  q_nxt = {q[0], q[WIDTH-1:1]};
               default: q_nxt = q;
            endcase
         end
      end else begin
         q_nxt     = {ser_in, q[WIDTH-1:1]};
         count_nxt = count - CW'(1);
         if (count == CW'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
         end
      end
   end

   assign ser_out = q[0];
   assign busy    = (state == SHIFT);

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench for universal_shift_register (WIDTH=4): modes, serial transfer,
// abort, back-to-back transfers, priority and asynchronous reset.
module tb_universal_shift_register;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic         clr;
   logic         en;
   logic [2:0]   mode;
   logic [W-1:0] d;
   logic         ser_in;
   logic         start;
   logic [W-1:0] q;
   logic         ser_out;
   logic         busy;
   logic         done;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] expq[$];
   logic         expb[$];

   universal_shift_register #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .en      (en),
      .mode    (mode),
      .d       (d),
      .ser_in  (ser_in),
      .start   (start),
      .q       (q),
      .ser_out (ser_out),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge so outputs are stable for sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [W-1:0] e;
      int seen;
      rst_n = 1'b0;
      #2;
      checks++;
      if (q !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_initial: q=%b busy=%b done=%b expected 0000/0/0", q, busy, done);
      end
      rst_n = 1'b1;
      step();
      en = 1'b1; mode = 3'b001; d = 4'b1011;
      expq.push_back(4'b1011);
      step();
      en = 1'b0;
      e = expq.pop_front();
      checks++;
      if (q !== e) begin
         errors++;
         $display("[TB] FAIL reset_load: q=%b expected %b", q, e);
      end
      start = 1'b1; d = 4'b1011;
      step();
      start = 1'b0;
      step();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_busy_before: busy=%b expected 1", busy);
      end
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (q !== 4'b0000 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_async: q=%b busy=%b expected 0000/0", q, busy);
      end
      step();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("[TB] FAIL reset_no_done: cycles with done/busy=%0d expected 0", seen);
      end
   endtask

   task automatic test_modes();
      logic         r_en[8]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [2:0]   r_mode[8] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b001};
      logic [W-1:0] r_d[8]    = '{4'b1011, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0101, 4'b0101, 4'b0000};
      logic         r_si[8]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [W-1:0] r_exp[8]  = '{4'b1011, 4'b0110, 4'b1011, 4'b0111, 4'b1011, 4'b1011, 4'b1011, 4'b1011};
      logic [W-1:0] e;
      for (int i = 0; i < 8; i++) begin
         en = r_en[i]; mode = r_mode[i]; d = r_d[i]; ser_in = r_si[i];
         expq.push_back(r_exp[i]);
         step();
         e = expq.pop_front();
         checks++;
         if (q !== e) begin
            errors++;
            $display("[TB] FAIL modes row %0d (mode %b en %b): q=%b expected %b", i, r_mode[i], r_en[i], q, e);
         end
      end
      en = 1'b0; mode = 3'b000;
   endtask

   task automatic test_transfer();
      logic         si_seq[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [W-1:0] dv;
      logic         b;
      logic [W-1:0] e;
      dv = 4'b0110;
      d = dv; start = 1'b1;
      for (int i = 0; i < W; i++) expb.push_back(dv[i]);
      expq.push_back(4'b1001);
      step();
      start = 1'b0;
      for (int i = 0; i < W; i++) begin
         b = expb.pop_front();
         checks++;
         if (ser_out !== b || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL transfer bit %0d: ser_out=%b busy=%b done=%b expected %b/1/0", i, ser_out, busy, done, b);
         end
         ser_in = si_seq[i];
         step();
      end
      e = expq.pop_front();
      checks++;
      if (busy !== 1'b0 || done !== 1'b1 || q !== e) begin
         errors++;
         $display("[TB] FAIL transfer_end: busy=%b done=%b q=%b expected 0/1/%b", busy, done, q, e);
      end
      step();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL transfer_done_pulse: done=%b expected 0", done);
      end
   endtask

   task automatic test_abort();
      int seen;
      d = 4'b1010; start = 1'b1;
      step();
      start = 1'b0; ser_in = 1'b1;
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      checks++;
      if (q !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort: q=%b busy=%b done=%b expected 0000/0/0", q, busy, done);
      end
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (done === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("[TB] FAIL abort_no_done: done cycles=%0d expected 0", seen);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] dv;
      logic         b;
      int           busyCount;
      d = 4'b0110; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (i == 1) begin
            start = 1'b1; d = 4'b1111;
         end else begin
            start = 1'b0;
         end
         step();
      end
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_first_done: done=%b busy=%b expected 1/0", done, busy);
      end
      dv = 4'b1100;
      d = dv; start = 1'b1;
      for (int i = 0; i < W; i++) expb.push_back(dv[i]);
      step();
      start = 1'b0;
      busyCount = 0;
      for (int i = 0; i < W; i++) begin
         b = expb.pop_front();
         if (busy === 1'b1) busyCount++;
         checks++;
         if (ser_out !== b || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b bit %0d: ser_out=%b busy=%b expected %b/1", i, ser_out, busy, b);
         end
         start = (i == 2);
         step();
      end
      start = 1'b0;
      if (busy === 1'b1) busyCount++;
      checks++;
      if (busyCount != W || done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_second_end: busy cycles=%0d done=%b expected %0d/1", busyCount, done, W);
      end
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_ignored_start: busy=%b done=%b expected 0/0", busy, done);
      end
   endtask

   task automatic test_priority();
      en = 1'b1; mode = 3'b001; d = 4'b0101;
      step();
      clr = 1'b1; start = 1'b1; en = 1'b1; mode = 3'b001; d = 4'b1111;
      expq.push_back(4'b0000);
      step();
      clr = 1'b0; start = 1'b0; en = 1'b0;
      checks++;
      if (q !== expq.pop_front() || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL priority: q=%b busy=%b expected 0000/0", q, busy);
      end
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; en = 1'b0; mode = 3'b000;
      d = '0; ser_in = 1'b0; start = 1'b0;
      test_reset();
      test_modes();
      test_transfer();
      test_abort();
      test_back_to_back();
      test_priority();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
